// File: rtl/iq_fifo_arbiter_pkg.sv
// Shared types and helpers for the I/Q FIFO round-robin arbiter.
package iq_arb_pkg;

  localparam int DW_DEFAULT = 24;

  typedef struct packed {
    logic [DW_DEFAULT-1:0] i;
    logic [DW_DEFAULT-1:0] q;
  } iq_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/iq_fifo_arbiter_rr_pick.sv
// Combinational wrap-around priority picker: first set req bit at or after start.
module rr_pick
  import iq_arb_pkg::*;
#(
  parameter int NCH = 2,
  parameter int IW  = ch_w(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  start,
  output logic           found,
  output logic [IW-1:0]  idx
);

  logic [IW-1:0] w_c;

  // Scan from the far end so the last hit written is the nearest to start.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    w_c   = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      w_c = IW'((int'(start) + k) % NCH);
      if (req[w_c]) begin
        found = 1'b1;
        idx   = w_c;
      end
    end
  end

endmodule

// File: rtl/iq_fifo_arbiter.sv
// Round-robin scheduler sharing one I/Q datapath among NCH sample FIFOs,
// with burst capping, a one-entry valid/ready output register and sticky overflow flags.
module iq_fifo_arbiter
  import iq_arb_pkg::*;
#(
  parameter  int NCH   = 2,
  parameter  int DW    = DW_DEFAULT,
  parameter  int BURST = 4,
  localparam int IW    = ch_w(NCH),
  localparam int CW    = $clog2(BURST + 1)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    enable,
  input  logic [NCH-1:0]          fifo_empty,
  input  logic [NCH-1:0]          fifo_full,
  input  logic [NCH-1:0]          fifo_push,
  input  logic [NCH-1:0][DW-1:0]  fifo_i,
  input  logic [NCH-1:0][DW-1:0]  fifo_q,
  output logic [NCH-1:0]          fifo_pull,
  output logic                    dp_valid,
  input  logic                    dp_ready,
  output logic [DW-1:0]           dp_i,
  output logic [DW-1:0]           dp_q,
  output logic [IW-1:0]           dp_ch,
  output logic [NCH-1:0]          ovf,
  input  logic [NCH-1:0]          ovf_clr
);

  localparam logic [IW-1:0] CH_LAST = IW'(NCH - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [IW-1:0]  r_cur;
  logic [CW-1:0]  r_cnt;
  logic           r_dp_valid;
  logic [DW-1:0]  r_dp_i;
  logic [DW-1:0]  r_dp_q;
  logic [IW-1:0]  r_dp_ch;
  logic [NCH-1:0] r_ovf;

  logic [NCH-1:0] w_req;
  logic [IW-1:0]  w_start;
  logic           w_found;
  logic [IW-1:0]  w_idx;
  logic           w_stay;
  logic [IW-1:0]  w_sel;
  logic           w_load;

  assign w_req   = ~fifo_empty;
  assign w_start = (r_cur == CH_LAST) ? '0 : r_cur + 1'b1;

  rr_pick #(
    .NCH (NCH),
    .IW  (IW)
  ) u_pick (
    .req   (w_req),
    .start (w_start),
    .found (w_found),
    .idx   (w_idx)
  );

  // cnt == 0 only after reset: no burst in progress, so the scan starting at channel 0 decides.
  assign w_stay = (r_cnt != '0) && (r_cnt < CNT_MAX) && !fifo_empty[r_cur];
  assign w_sel  = w_stay ? r_cur : w_idx;
  assign w_load = enable && (!r_dp_valid || dp_ready) && (w_stay || w_found);

  always_comb begin
    fifo_pull = '0;
    if (w_load) fifo_pull[w_sel] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur      <= CH_LAST;
      r_cnt      <= '0;
      r_dp_valid <= 1'b0;
      r_dp_i     <= '0;
      r_dp_q     <= '0;
      r_dp_ch    <= '0;
      r_ovf      <= '0;
    end else begin
      if (w_load) begin
        r_dp_valid <= 1'b1;
        r_dp_i     <= fifo_i[w_sel];
        r_dp_q     <= fifo_q[w_sel];
        r_dp_ch    <= w_sel;
        if (w_stay) begin
          r_cnt <= r_cnt + 1'b1;
        end else begin
          r_cur <= w_sel;
          r_cnt <= CNT_ONE;
        end
      end else if (dp_ready) begin
        r_dp_valid <= 1'b0;
      end
      // The FIFO drops a push while full even if it is pulled the same cycle.
      r_ovf <= (r_ovf & ~ovf_clr) | (fifo_push & fifo_full);
    end
  end

  assign dp_valid = r_dp_valid;
  assign dp_i     = r_dp_i;
  assign dp_q     = r_dp_q;
  assign dp_ch    = r_dp_ch;
  assign ovf      = r_ovf;

endmodule

// File: tb/tb_iq_fifo_arbiter.sv
// Directed bench for iq_fifo_arbiter: per-cycle vector table over small FIFO models,
// plus hand-written overflow and mid-burst reset sequences.
module tb_iq_fifo_arbiter;
  import iq_arb_pkg::*;

  localparam int DW = DW_DEFAULT;
  localparam logic [DW-1:0] QX = 24'h5A5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset_n, enable, dp_ready;
  logic [1:0] fifo_full, fifo_push, ovf_clr;
  logic [1:0] empty_a, empty_b, pull_a, pull_b, ovf_a, ovf_b;
  logic [1:0][DW-1:0] fi_a, fq_a, fi_b, fq_b;
  logic vld_a, vld_b, ch_a, ch_b;
  logic [DW-1:0] di_a, dq_a, di_b, dq_b;

  iq_fifo_arbiter #(.NCH(2), .DW(DW), .BURST(4)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_empty(empty_a), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_i(fi_a), .fifo_q(fq_a), .fifo_pull(pull_a),
    .dp_valid(vld_a), .dp_ready(dp_ready), .dp_i(di_a), .dp_q(dq_a), .dp_ch(ch_a),
    .ovf(ovf_a), .ovf_clr(ovf_clr)
  );

  iq_fifo_arbiter #(.NCH(2), .DW(DW), .BURST(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .fifo_empty(empty_b), .fifo_full(fifo_full), .fifo_push(fifo_push),
    .fifo_i(fi_b), .fifo_q(fq_b), .fifo_pull(pull_b),
    .dp_valid(vld_b), .dp_ready(dp_ready), .dp_i(di_b), .dp_q(dq_b), .dp_ch(ch_b),
    .ovf(ovf_b), .ovf_clr(ovf_clr)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // FIFO models: index 0 feeds DUT A, index 1 feeds DUT B.
  logic [DW-1:0] mem [2][2][4];
  int wr [2][2];
  int rd [2][2];
  logic [1:0] pull_v [2];
  logic [1:0] emp_v [2];
  logic [DW-1:0] head [2][2];

  assign pull_v[0] = pull_a;
  assign pull_v[1] = pull_b;

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 2; c++) begin
        emp_v[n][c] = !reset_n || (wr[n][c] == rd[n][c]);
        head[n][c]  = mem[n][c][rd[n][c][1:0]];
      end
    end
  end

  assign empty_a = emp_v[0];
  assign empty_b = emp_v[1];
  assign fi_a = {head[0][1], head[0][0]};
  assign fq_a = {head[0][1] ^ QX, head[0][0] ^ QX};
  assign fi_b = {head[1][1], head[1][0]};
  assign fq_b = {head[1][1] ^ QX, head[1][0] ^ QX};

  always @(posedge clk or negedge reset_n) begin
    for (int n = 0; n < 2; n++) begin
      for (int c = 0; c < 2; c++) begin
        if (!reset_n) begin
          rd[n][c] <= wr[n][c];
        end else if (pull_v[n][c]) begin
          chk($sformatf("pull_nonempty d%0d c%0d", n, c), 32'(wr[n][c] != rd[n][c]), 32'd1);
          rd[n][c] <= rd[n][c] + 1;
        end
      end
    end
  end

  task automatic push(input int n, input int c, input logic [DW-1:0] v);
    mem[n][c][wr[n][c][1:0]] = v;
    wr[n][c] = wr[n][c] + 1;
  endtask

  // Output view of whichever DUT the current vector targets.
  logic use_b;
  logic [1:0] o_pull;
  logic o_vld, o_ch;
  logic [DW-1:0] o_i, o_q;
  always_comb begin
    o_pull = use_b ? pull_b : pull_a;
    o_vld  = use_b ? vld_b  : vld_a;
    o_ch   = use_b ? ch_b   : ch_a;
    o_i    = use_b ? di_b   : di_a;
    o_q    = use_b ? dq_b   : dq_a;
  end

  typedef struct {
    int            ph;
    logic          en;
    logic          rdy;
    logic [1:0]    pull;
    logic          vld;
    logic          cd;
    logic [DW-1:0] di;
    logic          ch;
  } vec_t;

  vec_t tv[$];

  task automatic add(input int ph, input logic en, input logic rdy, input logic [1:0] pull,
                     input logic vld, input logic cd, input logic [DW-1:0] di, input logic ch);
    vec_t v;
    v.ph = ph; v.en = en; v.rdy = rdy; v.pull = pull;
    v.vld = vld; v.cd = cd; v.di = di; v.ch = ch;
    tv.push_back(v);
  endtask

  task automatic setup(input int ph);
    @(negedge clk);
    enable = 1'b0; dp_ready = 1'b1; reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    case (ph)
      1: for (int k = 1; k <= 3; k++) push(0, 0, DW'(k));
      2: for (int k = 0; k < 4; k++) begin
           push(0, 0, DW'(32'h10 + k));
           push(0, 1, DW'(32'h20 + k));
         end
      3: for (int k = 0; k < 4; k++) begin
           push(1, 0, DW'(32'h30 + k));
           push(1, 1, DW'(32'h40 + k));
         end
      4: begin push(0, 0, 24'h50); push(0, 0, 24'h51); end
      5: begin push(0, 0, 24'h60); push(0, 0, 24'h61); end
      default: ;
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int cur_ph;
    reset_n = 1'b0; enable = 1'b0; dp_ready = 1'b0; use_b = 1'b0;
    fifo_full = '0; fifo_push = '0; ovf_clr = '0;
    #2;
    chk("rst dp_valid", 32'(vld_a), 32'd0);
    chk("rst dp_i", 32'(di_a), 32'd0);
    chk("rst dp_q", 32'(dq_a), 32'd0);
    chk("rst dp_ch", 32'(ch_a), 32'd0);
    chk("rst ovf", 32'(ovf_a), 32'd0);
    chk("rst pull", 32'(pull_a), 32'd0);

    // Single channel: three samples back to back, then idle.
    add(1, 1, 1, 2'b01, 1, 1, 24'h1, 0);
    add(1, 1, 1, 2'b01, 1, 1, 24'h2, 0);
    add(1, 1, 1, 2'b01, 1, 1, 24'h3, 0);
    add(1, 1, 1, 2'b00, 0, 0, 24'h0, 0);
    // BURST=4: four to ch0, four to ch1, no bubble.
    for (int k = 0; k < 4; k++) add(2, 1, 1, 2'b01, 1, 1, DW'(32'h10 + k), 0);
    for (int k = 0; k < 4; k++) add(2, 1, 1, 2'b10, 1, 1, DW'(32'h20 + k), 1);
    add(2, 1, 1, 2'b00, 0, 0, 24'h0, 0);
    // BURST=2 instance: 0,0,1,1,0,0,1,1.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 2; k++) add(3, 1, 1, 2'b01, 1, 1, DW'(32'h30 + 2 * r + k), 0);
      for (int k = 0; k < 2; k++) add(3, 1, 1, 2'b10, 1, 1, DW'(32'h40 + 2 * r + k), 1);
    end
    add(3, 1, 1, 2'b00, 0, 0, 24'h0, 0);
    // Enable low blocks pulls; back-pressure holds one sample stable.
    add(4, 0, 1, 2'b00, 0, 0, 24'h0, 0);
    add(4, 1, 0, 2'b01, 1, 1, 24'h50, 0);
    for (int k = 0; k < 4; k++) add(4, 1, 0, 2'b00, 1, 1, 24'h50, 0);
    add(4, 1, 1, 2'b01, 1, 1, 24'h51, 0);
    add(4, 1, 1, 2'b00, 0, 0, 24'h0, 0);
    // Pending sample drains while enable is low.
    add(5, 1, 0, 2'b01, 1, 1, 24'h60, 0);
    add(5, 0, 0, 2'b00, 1, 1, 24'h60, 0);
    add(5, 0, 1, 2'b00, 0, 0, 24'h0, 0);
    add(5, 1, 1, 2'b01, 1, 1, 24'h61, 0);

    cur_ph = 0;
    foreach (tv[i]) begin
      if (tv[i].ph != cur_ph) begin
        setup(tv[i].ph);
        cur_ph = tv[i].ph;
        use_b = (cur_ph == 3);
      end
      enable = tv[i].en;
      dp_ready = tv[i].rdy;
      #1;
      chk($sformatf("v%0d pull", i), 32'(o_pull), 32'(tv[i].pull));
      @(posedge clk);
      #1;
      chk($sformatf("v%0d dp_valid", i), 32'(o_vld), 32'(tv[i].vld));
      if (tv[i].cd) begin
        chk($sformatf("v%0d dp_i", i), 32'(o_i), 32'(tv[i].di));
        chk($sformatf("v%0d dp_q", i), 32'(o_q), 32'(tv[i].di ^ QX));
        chk($sformatf("v%0d dp_ch", i), 32'(o_ch), 32'(tv[i].ch));
      end
      @(negedge clk);
    end
    use_b = 1'b0;

    // Sticky overflow: set, set-wins-over-clear, clear, per-channel independence.
    enable = 1'b0;
    fifo_full = 2'b10; fifo_push = 2'b10;
    @(posedge clk); #1;
    chk("ovf set ch1", 32'(ovf_a), 32'h2);
    chk("ovf set ch1 b", 32'(ovf_b), 32'h2);
    @(negedge clk); ovf_clr = 2'b10;
    @(posedge clk); #1;
    chk("ovf set wins clr", 32'(ovf_a), 32'h2);
    @(negedge clk); fifo_full = '0; fifo_push = '0;
    @(posedge clk); #1;
    chk("ovf clr ch1", 32'(ovf_a), 32'h0);
    @(negedge clk); ovf_clr = '0; fifo_push = 2'b01;
    @(posedge clk); #1;
    chk("ovf push not full", 32'(ovf_a), 32'h0);
    @(negedge clk); fifo_full = 2'b01;
    @(posedge clk); #1;
    chk("ovf set ch0", 32'(ovf_a), 32'h1);
    @(negedge clk); fifo_full = '0; fifo_push = '0; ovf_clr = 2'b01;
    @(posedge clk); #1;
    chk("ovf clr ch0", 32'(ovf_a), 32'h0);

    // Reset asserted mid-burst, then first grant after release goes to ch0.
    @(negedge clk); ovf_clr = '0; reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      push(0, 0, DW'(32'h70 + k));
      push(0, 1, DW'(32'h80 + k));
    end
    enable = 1'b1; dp_ready = 1'b1; fifo_full = 2'b10; fifo_push = 2'b10;
    @(posedge clk);
    @(negedge clk); fifo_full = '0; fifo_push = '0;
    @(posedge clk); #1;
    chk("pre-rst dp_valid", 32'(vld_a), 32'd1);
    chk("pre-rst dp_i", 32'(di_a), 32'h71);
    chk("pre-rst ovf", 32'(ovf_a), 32'h2);
    #2; reset_n = 1'b0; #1;
    chk("mid-rst dp_valid", 32'(vld_a), 32'd0);
    chk("mid-rst dp_i", 32'(di_a), 32'd0);
    chk("mid-rst ovf", 32'(ovf_a), 32'd0);
    chk("mid-rst pull", 32'(pull_a), 32'd0);
    @(negedge clk); reset_n = 1'b1;
    push(0, 0, 24'h90);
    push(0, 1, 24'hA0);
    #1;
    chk("post-rst pull ch0", 32'(pull_a), 32'h1);
    @(posedge clk); #1;
    chk("post-rst dp_ch", 32'(ch_a), 32'd0);
    chk("post-rst dp_i", 32'(di_a), 32'h90);
    chk("post-rst pull ch1", 32'(pull_a), 32'h2);
    @(posedge clk); #1;
    chk("post-rst dp_ch 2", 32'(ch_a), 32'd1);
    chk("post-rst dp_i 2", 32'(di_a), 32'hA0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
